// File: rtl/dbus_arb_pkg.sv
// Shared encodings for the DDR bus round-robin arbiter: FSM states,
// arbitration modes and command opcodes.
package dbus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    localparam logic DBUS_WRITE = 1'b1;
    localparam logic DBUS_READ  = 1'b0;

endpackage

// File: rtl/rr_picker.sv
// Winner selection: rotating search starting after ptr, or lowest index
// first when mode is set. Purely combinational.
module rr_picker #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    input  logic              mode,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    int   cand;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            // Fixed mode walks 0..N-1; round-robin walks ptr+1 .. ptr, wrapping.
            cand = mode ? i : (int'(ptr) + 1 + i) % NUM_CH;
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                   = 1'b1;
                grant[cand[IDX_W-1:0]]  = 1'b1;
                grant_idx               = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dbus_rr_arb.sv
// Multi-channel arbiter in front of a single DDR command port: grants one
// request, issues it for one cycle, waits for done or timeout, then responds.
module dbus_rr_arb
    import dbus_arb_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 512,
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 1023
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH*ADDR_W-1:0] req_index,
    input  logic [NUM_CH-1:0]        req_write,
    input  logic [NUM_CH-1:0]        req_burst,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    input  logic [NUM_CH*DATA_W-1:0] req_wmask,
    output logic [NUM_CH-1:0]        rsp_done,
    output logic                     rsp_error,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     ddr_chip_enable,
    output logic [ADDR_W-1:0]        ddr_index,
    output logic                     ddr_write_enable,
    output logic                     ddr_burst_mode,
    output logic [DATA_W-1:0]        ddr_write_data,
    output logic [DATA_W-1:0]        ddr_write_mask,
    input  logic [DATA_W-1:0]        ddr_read_data,
    input  logic                     ddr_operation_done,
    input  logic                     ddr_ready,
    output logic [1:0]               dbg_state
);

    localparam int          IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

    arb_state_t        state, state_nxt;
    logic [IDX_W-1:0]  rr_ptr, owner;
    logic [15:0]       wait_cnt;
    logic [ADDR_W-1:0] cap_index;
    logic              cap_write, cap_burst;
    logic [DATA_W-1:0] cap_wdata, cap_wmask;
    logic [NUM_CH-1:0] pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              grant_fire, complete, timed_out, active;

    // Handshake: a request is accepted in the cycle where req_valid[g] and
    // req_ready[g] are both 1; req_ready is only ever raised in IDLE.
    rr_picker #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_picker (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .mode      (PRIO_MODE == PRIO_FIXED),
        .grant     (pick_grant),
        .grant_idx (pick_idx)
    );

    always_comb begin
        state_nxt  = state;
        grant_fire = 1'b0;
        complete   = 1'b0;
        timed_out  = 1'b0;
        case (state)
            ST_IDLE: begin
                // reset_n gates the grant so req_ready stays low while held in reset.
                if (reset_n && (|req_valid) && ddr_ready) begin
                    grant_fire = 1'b1;
                    state_nxt  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ddr_operation_done) begin
                    complete  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ddr_operation_done) begin
                    complete  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (wait_cnt == TIMEOUT_M1) begin
                    timed_out = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        active           = (state != ST_IDLE);
        req_ready        = grant_fire ? pick_grant : '0;
        ddr_chip_enable  = (state == ST_ISSUE);
        ddr_index        = active ? cap_index : '0;
        ddr_write_enable = active && (cap_write == DBUS_WRITE);
        ddr_burst_mode   = active && cap_burst;
        ddr_write_data   = active ? cap_wdata : '0;
        ddr_write_mask   = active ? cap_wmask : '0;
        dbg_state        = state;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= IDX_W'(NUM_CH - 1);
            owner     <= '0;
            wait_cnt  <= '0;
            cap_index <= '0;
            cap_write <= 1'b0;
            cap_burst <= 1'b0;
            cap_wdata <= '0;
            cap_wmask <= '0;
            rsp_done  <= '0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            rsp_done  <= '0;
            rsp_error <= 1'b0;
            wait_cnt  <= (state == ST_WAIT) ? wait_cnt + 16'd1 : 16'd0;
            if (grant_fire) begin
                rr_ptr    <= pick_idx;
                owner     <= pick_idx;
                cap_index <= req_index[int'(pick_idx)*ADDR_W +: ADDR_W];
                cap_write <= req_write[pick_idx];
                cap_burst <= req_burst[pick_idx];
                cap_wdata <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                cap_wmask <= req_wmask[int'(pick_idx)*DATA_W +: DATA_W];
            end
            // A timeout completes without touching rsp_rdata.
            if (complete) begin
                rsp_done[owner] <= 1'b1;
                rsp_rdata       <= ddr_read_data;
            end else if (timed_out) begin
                rsp_done[owner] <= 1'b1;
                rsp_error       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dbus_rr_arb.sv
// Bench for dbus_rr_arb: three instances (4-ch round-robin, 4-ch fixed,
// 2-ch round-robin) sharing request stimulus, each with its own ddr_ready.
module tb_dbus_rr_arb;
    import dbus_arb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int EW = 53;

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- stimulus ----------------
    logic [3:0]      req_valid;
    logic [3:0]      chan_write;
    logic [3:0]      chan_burst;
    logic [AW-1:0]   chan_idx   [4];
    logic [DW-1:0]   chan_wdata [4];
    logic [DW-1:0]   chan_wmask [4];
    logic [4*AW-1:0] req_index;
    logic [4*DW-1:0] req_wdata, req_wmask;
    logic [DW-1:0]   ddr_read_data;
    logic            ddr_operation_done;
    logic [2:0]      rdy;

    always_comb begin
        req_index = '0;
        req_wdata = '0;
        req_wmask = '0;
        for (int c = 0; c < 4; c++) begin
            req_index[c*AW +: AW] = chan_idx[c];
            req_wdata[c*DW +: DW] = chan_wdata[c];
            req_wmask[c*DW +: DW] = chan_wmask[c];
        end
    end

    // ---------------- DUT outputs, indexed by instance ----------------
    logic [3:0]    o_ready [3];
    logic [3:0]    o_done  [3];
    logic          o_err   [3];
    logic [DW-1:0] o_rdata [3];
    logic          o_ce    [3];
    logic [AW-1:0] o_idx   [3];
    logic          o_we    [3];
    logic          o_bm    [3];
    logic [DW-1:0] o_wd    [3];
    logic [DW-1:0] o_wm    [3];
    logic [1:0]    o_st    [3];
    logic [1:0]    two_ready, two_done;

    assign o_ready[2] = {2'b00, two_ready};
    assign o_done[2]  = {2'b00, two_done};

    dbus_rr_arb #(.NUM_CH(4), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0), .TIMEOUT(TO)) dut_rr (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(o_ready[0]), .req_index(req_index),
        .req_write(chan_write), .req_burst(chan_burst),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_done(o_done[0]), .rsp_error(o_err[0]), .rsp_rdata(o_rdata[0]),
        .ddr_chip_enable(o_ce[0]), .ddr_index(o_idx[0]), .ddr_write_enable(o_we[0]),
        .ddr_burst_mode(o_bm[0]), .ddr_write_data(o_wd[0]), .ddr_write_mask(o_wm[0]),
        .ddr_read_data(ddr_read_data), .ddr_operation_done(ddr_operation_done),
        .ddr_ready(rdy[0]), .dbg_state(o_st[0])
    );

    dbus_rr_arb #(.NUM_CH(4), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1), .TIMEOUT(TO)) dut_fx (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(o_ready[1]), .req_index(req_index),
        .req_write(chan_write), .req_burst(chan_burst),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_done(o_done[1]), .rsp_error(o_err[1]), .rsp_rdata(o_rdata[1]),
        .ddr_chip_enable(o_ce[1]), .ddr_index(o_idx[1]), .ddr_write_enable(o_we[1]),
        .ddr_burst_mode(o_bm[1]), .ddr_write_data(o_wd[1]), .ddr_write_mask(o_wm[1]),
        .ddr_read_data(ddr_read_data), .ddr_operation_done(ddr_operation_done),
        .ddr_ready(rdy[1]), .dbg_state(o_st[1])
    );

    dbus_rr_arb #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0), .TIMEOUT(1023)) dut_two (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid[1:0]), .req_ready(two_ready), .req_index(req_index[2*AW-1:0]),
        .req_write(chan_write[1:0]), .req_burst(chan_burst[1:0]),
        .req_wdata(req_wdata[2*DW-1:0]), .req_wmask(req_wmask[2*DW-1:0]),
        .rsp_done(two_done), .rsp_error(o_err[2]), .rsp_rdata(o_rdata[2]),
        .ddr_chip_enable(o_ce[2]), .ddr_index(o_idx[2]), .ddr_write_enable(o_we[2]),
        .ddr_burst_mode(o_bm[2]), .ddr_write_data(o_wd[2]), .ddr_write_mask(o_wm[2]),
        .ddr_read_data(ddr_read_data), .ddr_operation_done(ddr_operation_done),
        .ddr_ready(rdy[2]), .dbg_state(o_st[2])
    );

    // ---------------- scoreboard ----------------
    int            checks   = 0;
    int            failures = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    logic [DW-1:0] last_rd [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Entry layout: {due cycle[15:0], instance[1:0], channel[1:0], error, rdata[31:0]}
    task automatic push_exp(input int due, input int d, input int ch, input logic err,
                            input logic [DW-1:0] rd);
        exp_q.push_back({16'(due), 2'(d), 2'(ch), err, rd});
    endtask

    always @(negedge clock) begin
        #2;
        for (int d = 0; d < 3; d++) begin
            if (o_done[d] != 4'b0) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", o_done[d], 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_instance", d, mon_e[36:35]);
                    check("rsp_done", o_done[d], 4'b0001 << mon_e[34:33]);
                    check("rsp_error", o_err[d], mon_e[32]);
                    check("rsp_rdata", o_rdata[d], mon_e[31:0]);
                    check("rsp_cycle", cyc, mon_e[52:37]);
                end
            end
        end
        if (exp_q.size() != 0 && int'(exp_q[0][52:37]) < cyc) begin
            checks++;
            failures++;
            $display("FAIL rsp_missing: cycle %0d passed due cycle %0d with no rsp_done",
                     cyc, exp_q[0][52:37]);
            void'(exp_q.pop_front());
        end
    end

    // ---------------- driver ----------------
    // Called right at a falling edge; returns at the falling edge of the
    // cycle in which rsp_done is expected (so the next call overlaps it).
    task automatic run_txn(input int s, input logic [3:0] v, input int ch, input int dd,
                           input int rdly, input bit drop);
        int            waited;
        int            last;
        logic [DW-1:0] rd;
        req_valid = v;
        rdy       = 3'b000;
        for (int k = 0; k < rdly; k++) begin
            #1;
            check("ready_while_ddr_busy", o_ready[s], 64'd0);
            @(negedge clock);
        end
        rdy[s] = 1'b1;
        #1;
        waited = 0;
        while (o_ready[s] == 4'b0 && waited < 20) begin
            @(negedge clock);
            #1;
            waited++;
        end
        check("grant", o_ready[s], 4'b0001 << ch);
        last = (dd < 0) ? TO : dd;
        for (int k = 0; k <= last; k++) begin
            @(negedge clock);
            if (k == 0 && drop) req_valid = 4'b0000;
            if (k == 0 && dd < 0) push_exp(cyc + TO + 1, s, ch, 1'b1, last_rd[s]);
            if (k == last && dd >= 0) begin
                rd                 = $urandom;
                ddr_read_data      = rd;
                ddr_operation_done = 1'b1;
                push_exp(cyc + 1, s, ch, 1'b0, rd);
                last_rd[s] = rd;
            end
            #1;
            check("chip_enable", o_ce[s], 64'(k == 0));
            check("ready_while_busy", o_ready[s], 64'd0);
            check("state", o_st[s], (k == 0) ? ST_ISSUE : ST_WAIT);
            check("ddr_index", o_idx[s], chan_idx[ch]);
            check("write_enable", o_we[s], chan_write[ch]);
            if (k == 0) begin
                check("burst_mode", o_bm[s], chan_burst[ch]);
                check("write_data", o_wd[s], chan_wdata[ch]);
                check("write_mask", o_wm[s], chan_wmask[ch]);
            end
        end
        @(negedge clock);
        ddr_operation_done = 1'b0;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int         s;      // instance: 0 rr4, 1 fixed4, 2 rr2
        logic [3:0] v;      // req_valid
        int         ch;     // expected winner
        int         dd;     // done delay after chip_enable, -1 = never
        int         rdly;   // cycles of ddr_ready=0 before the grant
        bit         drop;   // drop req_valid after the grant
    } vec_t;

    vec_t vecs [16];

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2, 4'b0001, 0,  3, 0, 1'b1};
        vecs[1]  = '{2, 4'b0011, 1,  0, 0, 1'b0};
        vecs[2]  = '{2, 4'b0011, 0,  1, 0, 1'b0};
        vecs[3]  = '{0, 4'b1111, 0,  2, 0, 1'b0};
        vecs[4]  = '{0, 4'b1111, 1,  0, 0, 1'b0};
        vecs[5]  = '{0, 4'b1111, 2,  1, 0, 1'b0};
        vecs[6]  = '{0, 4'b1111, 3,  4, 0, 1'b0};
        vecs[7]  = '{0, 4'b1111, 0,  2, 0, 1'b0};
        vecs[8]  = '{0, 4'b1001, 3,  1, 0, 1'b0};
        vecs[9]  = '{0, 4'b0001, 0,  1, 0, 1'b0};
        vecs[10] = '{0, 4'b0100, 2,  2, 5, 1'b0};
        vecs[11] = '{1, 4'b1010, 1,  1, 0, 1'b0};
        vecs[12] = '{1, 4'b1010, 1,  2, 0, 1'b0};
        vecs[13] = '{1, 4'b1000, 3,  1, 0, 1'b0};
        vecs[14] = '{1, 4'b1111, 0,  0, 0, 1'b0};
        vecs[15] = '{0, 4'b0010, 1, -1, 0, 1'b1};

        chan_idx[0] = 16'h0040;
        chan_idx[1] = 16'h1234;
        chan_idx[2] = 16'h0BEE;
        chan_idx[3] = 16'hFFC0;
        chan_write  = 4'b0110;
        chan_burst  = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            chan_wdata[c] = $urandom;
            chan_wmask[c] = $urandom;
        end
        chan_wmask[2] = 32'hFFFF_FFFF;
        for (int d = 0; d < 3; d++) last_rd[d] = '0;

        // Held in reset with every request and ddr_ready high: all outputs stay 0.
        req_valid          = 4'b1111;
        rdy                = 3'b111;
        ddr_operation_done = 1'b0;
        ddr_read_data      = '0;
        repeat (3) @(negedge clock);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("reset_ready", o_ready[d], 64'd0);
            check("reset_chip_enable", o_ce[d], 64'd0);
            check("reset_state", o_st[d], ST_IDLE);
            check("reset_rdata", o_rdata[d], 64'd0);
            check("reset_done", o_done[d], 64'd0);
        end
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++)
            run_txn(vecs[i].s, vecs[i].v, vecs[i].ch, vecs[i].dd, vecs[i].rdly, vecs[i].drop);

        // done arriving while idle must be ignored
        rdy       = 3'b000;
        req_valid = 4'b0000;
        @(negedge clock);
        ddr_operation_done = 1'b1;
        @(negedge clock);
        ddr_operation_done = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check("idle_done_ignored", o_done[d], 64'd0);
            check("idle_state", o_st[d], ST_IDLE);
        end

        // Reset during WAIT aborts silently and restores the pointer to ch0.
        @(negedge clock);
        req_valid = 4'b0010;
        rdy       = 3'b001;
        #1;
        check("pre_reset_grant", o_ready[0], 64'b0010);
        @(negedge clock);
        req_valid = 4'b1111;
        #1;
        check("pre_reset_issue", o_st[0], ST_ISSUE);
        @(negedge clock);
        #1;
        check("pre_reset_wait", o_st[0], ST_WAIT);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("abort_state", o_st[0], ST_IDLE);
        check("abort_ready", o_ready[0], 64'd0);
        check("abort_chip_enable", o_ce[0], 64'd0);
        check("abort_index", o_idx[0], 64'd0);
        check("abort_write_mask", o_wm[0], 64'd0);
        check("abort_rdata", o_rdata[0], 64'd0);
        check("abort_done", o_done[0], 64'd0);
        @(negedge clock);
        #1;
        check("abort_ready_held", o_ready[0], 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int d = 0; d < 3; d++) last_rd[d] = '0;
        run_txn(0, 4'b1111, 0, 2, 0, 1'b0);
        req_valid = 4'b0000;
        rdy       = 3'b000;

        repeat (3) @(negedge clock);
        #3;
        check("pending_responses", exp_q.size(), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
